// File: rtl/pb_debouncer_multi.sv
`default_nettype none
// ============================================================================
// Module      : pb_debouncer_multi
// Description : N-channel push-button debouncer for front-panel button banks.
//               Each channel has a 2-FF synchronizer, a stable-time debounce
//               counter, a debounced level, one-cycle press/release pulses
//               and a one-cycle long-press (hold) pulse. Channels share no
//               state.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N             number of independent button channels (>= 1)
//   DELAY         consecutive synchronized-mismatch cycles needed to accept a
//                 level change (>= 2)
//   HOLD_CYCLES   cycles the status must stay high after the press before the
//                 hold pulse fires (>= 1)
//   REPEAT_CYCLES auto-repeat period after the hold pulse (>= 1)
//
// Ports
//   clk               in   1  system clock
//   reset             in   1  asynchronous, active-high reset
//   pb                in   N  raw asynchronous button inputs, active-high
//   pb_status         out  N  debounced level, 1 = pressed
//   pb_pressed_pulse  out  N  one-cycle pulse on accepted press
//   pb_released_pulse out  N  one-cycle pulse on accepted release
//   pb_hold_pulse     out  N  one-cycle pulse after HOLD_CYCLES of press
//   pb_repeat_pulse   out  N  one-cycle auto-repeat pulse
//
// Build option
//   PB_AUTOREPEAT_EN  when defined, each channel gets a repeat counter that
//                     fires pb_repeat_pulse every REPEAT_CYCLES cycles after
//                     the hold pulse while the button stays pressed. When not
//                     defined, pb_repeat_pulse is tied to 0. The port list is
//                     the same in both builds.
// ============================================================================
module pb_debouncer_multi #(
    parameter int N             = 4,
    parameter int DELAY         = 15,
    parameter int HOLD_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 250
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] pb,
    output logic [N-1:0] pb_status,
    output logic [N-1:0] pb_pressed_pulse,
    output logic [N-1:0] pb_released_pulse,
    output logic [N-1:0] pb_hold_pulse,
    output logic [N-1:0] pb_repeat_pulse
);

    // Counter widths are sized so each counter can represent its limit.
    localparam int c_DCNT_W = $clog2(DELAY + 1);
    localparam int c_HCNT_W = $clog2(HOLD_CYCLES + 1);

    // Debounce counter value on the last mismatch cycle before the toggle.
    localparam logic [c_DCNT_W-1:0] c_DCNT_LAST = c_DCNT_W'(DELAY - 1);
    localparam logic [c_DCNT_W-1:0] c_DCNT_ONE  = c_DCNT_W'(1);

    // Hold counter saturates at HOLD_CYCLES; the pulse fires on the edge that
    // moves it from HOLD_CYCLES-1 to HOLD_CYCLES, so it can only fire once.
    localparam logic [c_HCNT_W-1:0] c_HCNT_MAX = c_HCNT_W'(HOLD_CYCLES);
    localparam logic [c_HCNT_W-1:0] c_HCNT_PRE = c_HCNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_HCNT_W-1:0] c_HCNT_ONE = c_HCNT_W'(1);

`ifdef PB_AUTOREPEAT_EN
    localparam int c_RCNT_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [c_RCNT_W-1:0] c_RCNT_PRE = c_RCNT_W'(REPEAT_CYCLES - 1);
    localparam logic [c_RCNT_W-1:0] c_RCNT_ONE = c_RCNT_W'(1);
`endif

    for (genvar i = 0; i < N; i++) begin : g_ch

        // ------------------------------------------------------------------
        // Per-channel state
        // ------------------------------------------------------------------
        logic                s1_q;
        logic                pb_sync_q;
        logic                status_q,   status_d;
        logic [c_DCNT_W-1:0] dcnt_q,     dcnt_d;
        logic                pressed_q,  pressed_d;
        logic                released_q, released_d;
        logic [c_HCNT_W-1:0] hcnt_q,     hcnt_d;
        logic                hold_q,     hold_d;
        logic                hold_run;

        // ------------------------------------------------------------------
        // Debounce, edge pulses and hold detection
        // ------------------------------------------------------------------
        always_comb begin
            status_d   = status_q;
            dcnt_d     = '0;
            pressed_d  = 1'b0;
            released_d = 1'b0;
            hcnt_d     = '0;
            hold_d     = 1'b0;
            hold_run   = 1'b0;

            // Any agreeing cycle restarts the count, so a glitch shorter than
            // DELAY synchronized cycles never reaches the toggle point.
            if (pb_sync_q != status_q) begin
                if (dcnt_q == c_DCNT_LAST) begin
                    status_d = ~status_q;
                    dcnt_d   = '0;
                end else begin
                    dcnt_d = dcnt_q + c_DCNT_ONE;
                end
            end

            // Pulses are registered alongside the status flop, so they line
            // up with the first cycle the new level is visible.
            pressed_d  =  status_d & ~status_q;
            released_d = ~status_d &  status_q;

            // The hold counter only advances while the button was pressed and
            // stays pressed across this edge. Gating on status_d keeps a hold
            // pulse from coinciding with the release pulse.
            hold_run = status_q & status_d;
            if (hold_run) begin
                if (hcnt_q == c_HCNT_MAX) begin
                    hcnt_d = hcnt_q;
                end else begin
                    hcnt_d = hcnt_q + c_HCNT_ONE;
                end
                hold_d = (hcnt_q == c_HCNT_PRE);
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1_q       <= 1'b0;
                pb_sync_q  <= 1'b0;
                status_q   <= 1'b0;
                dcnt_q     <= '0;
                pressed_q  <= 1'b0;
                released_q <= 1'b0;
                hcnt_q     <= '0;
                hold_q     <= 1'b0;
            end else begin
                s1_q       <= pb[i];
                pb_sync_q  <= s1_q;
                status_q   <= status_d;
                dcnt_q     <= dcnt_d;
                pressed_q  <= pressed_d;
                released_q <= released_d;
                hcnt_q     <= hcnt_d;
                hold_q     <= hold_d;
            end
        end

        assign pb_status[i]         = status_q;
        assign pb_pressed_pulse[i]  = pressed_q;
        assign pb_released_pulse[i] = released_q;
        assign pb_hold_pulse[i]     = hold_q;

`ifdef PB_AUTOREPEAT_EN
        // ------------------------------------------------------------------
        // Auto-repeat: runs only once the hold counter has saturated, i.e.
        // on edges after the hold pulse. It sits at 0 on the hold edge and
        // wraps every REPEAT_CYCLES edges, firing on each wrap.
        // ------------------------------------------------------------------
        logic [c_RCNT_W-1:0] rcnt_q, rcnt_d;
        logic                rep_q,  rep_d;
        logic                rep_run;

        always_comb begin
            rcnt_d  = '0;
            rep_d   = 1'b0;
            rep_run = hold_run && (hcnt_q == c_HCNT_MAX);
            if (rep_run) begin
                if (rcnt_q == c_RCNT_PRE) begin
                    rcnt_d = '0;
                    rep_d  = 1'b1;
                end else begin
                    rcnt_d = rcnt_q + c_RCNT_ONE;
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rcnt_q <= '0;
                rep_q  <= 1'b0;
            end else begin
                rcnt_q <= rcnt_d;
                rep_q  <= rep_d;
            end
        end

        assign pb_repeat_pulse[i] = rep_q;
`else
        assign pb_repeat_pulse[i] = 1'b0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_pb_debouncer_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_pb_debouncer_multi
// Description : Self-checking bench for pb_debouncer_multi (N=2, DELAY=4,
//               HOLD_CYCLES=20, REPEAT_CYCLES=8). A behavioural model derives
//               expected outputs from the button history; directed scenarios
//               pin key timings with literal values, then random stimulus
//               with occasional asynchronous resets follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pb_debouncer_multi;

    localparam int N      = 2;
    localparam int DELAY  = 4;
    localparam int HOLD   = 20;
    localparam int REPEAT = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] pb  = '0;
    logic [N-1:0] pb_status;
    logic [N-1:0] pb_pressed_pulse;
    logic [N-1:0] pb_released_pulse;
    logic [N-1:0] pb_hold_pulse;
    logic [N-1:0] pb_repeat_pulse;

    int checks   = 0;
    int failures = 0;
    int cur      = 0;

    pb_debouncer_multi #(
        .N             (N),
        .DELAY         (DELAY),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REPEAT)
    ) dut (
        .clk               (clk),
        .reset             (rst),
        .pb                (pb),
        .pb_status         (pb_status),
        .pb_pressed_pulse  (pb_pressed_pulse),
        .pb_released_pulse (pb_released_pulse),
        .pb_hold_pulse     (pb_hold_pulse),
        .pb_repeat_pulse   (pb_repeat_pulse)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model. The compared input is the pb value seen two edges
    // earlier; a level is accepted after DELAY consecutive differing edges.
    // 'age' counts cycles the debounced level has been high (1 = press
    // cycle). Hold fires at age HOLD+1; repeats at every REPEAT multiple
    // past that point.
    // ------------------------------------------------------------------
    bit           d1   [N];
    bit           d2   [N];
    bit           st   [N];
    bit           prv  [N];
    int           run  [N];
    int           age  [N];
    logic [N-1:0] exp_status   = '0;
    logic [N-1:0] exp_pressed  = '0;
    logic [N-1:0] exp_released = '0;
    logic [N-1:0] exp_hold     = '0;
    logic [N-1:0] exp_repeat   = '0;

    initial begin
        for (int c = 0; c < N; c++) begin
            d1[c] = 0; d2[c] = 0; st[c] = 0; prv[c] = 0; run[c] = 0; age[c] = 0;
        end
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int c = 0; c < N; c++) begin
                    d1[c] = 0; d2[c] = 0; st[c] = 0; prv[c] = 0;
                    run[c] = 0; age[c] = 0;
                end
                exp_status = '0; exp_pressed = '0; exp_released = '0;
                exp_hold = '0; exp_repeat = '0;
            end else begin
                for (int c = 0; c < N; c++) begin
                    bit cmp;
                    cmp   = d2[c];
                    d2[c] = d1[c];
                    d1[c] = pb[c];
                    if (cmp != st[c]) begin
                        run[c] = run[c] + 1;
                        if (run[c] == DELAY) begin
                            st[c]  = ~st[c];
                            run[c] = 0;
                        end
                    end else begin
                        run[c] = 0;
                    end
                    age[c] = st[c] ? age[c] + 1 : 0;
                    exp_status[c]   = st[c];
                    exp_pressed[c]  = st[c] && !prv[c];
                    exp_released[c] = !st[c] && prv[c];
                    exp_hold[c]     = st[c] && (age[c] == HOLD + 1);
`ifdef PB_AUTOREPEAT_EN
                    exp_repeat[c]   = st[c] && (age[c] > HOLD + 1) &&
                                      (((age[c] - HOLD - 1) % REPEAT) == 0);
`else
                    exp_repeat[c]   = 1'b0;
`endif
                    prv[c] = st[c];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [N-1:0] act,
                       input logic [N-1:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, req);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("model_status",   pb_status,         exp_status);
        chk("model_pressed",  pb_pressed_pulse,  exp_pressed);
        chk("model_released", pb_released_pulse, exp_released);
        chk("model_hold",     pb_hold_pulse,     exp_hold);
        chk("model_repeat",   pb_repeat_pulse,   exp_repeat);
    end

    // Advance to 2 time units after edge k of the current scenario.
    task automatic goto_edge(input int k);
        repeat (k - cur) @(posedge clk);
        cur = k;
        #2;
    endtask

    task automatic start_scenario(input logic [N-1:0] v);
        @(posedge clk);
        #2;
        pb  = v;
        cur = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_status"},   pb_status,         2'b00);
        chk({tag, "_pressed"},  pb_pressed_pulse,  2'b00);
        chk({tag, "_released"}, pb_released_pulse, 2'b00);
        chk({tag, "_hold"},     pb_hold_pulse,     2'b00);
        chk({tag, "_repeat"},   pb_repeat_pulse,   2'b00);
    endtask

    int left [N];

    initial begin
        // Asynchronous reset with no clock edge yet.
        #1 rst = 1'b1;
        #1 chk_all_zero("reset_async");
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);

        // Clean press on channel 0, glitch on channel 1, hold, repeat, release.
        start_scenario(2'b01);
        goto_edge(5);
        chk("press_e5_status", pb_status, 2'b00);
        goto_edge(6);
        chk("press_e6_status",  pb_status,        2'b01);
        chk("press_e6_pressed", pb_pressed_pulse, 2'b01);
        goto_edge(7);
        chk("press_e7_pressed", pb_pressed_pulse, 2'b00);
        pb[1] = 1'b1;
        goto_edge(10);
        pb[1] = 1'b0;
        goto_edge(20);
        chk("glitch_e20_status", pb_status, 2'b01);
        goto_edge(25);
        chk("hold_e25", pb_hold_pulse, 2'b00);
        goto_edge(26);
        chk("hold_e26", pb_hold_pulse, 2'b01);
        goto_edge(27);
        chk("hold_e27", pb_hold_pulse, 2'b00);
        goto_edge(34);
`ifdef PB_AUTOREPEAT_EN
        chk("repeat_e34", pb_repeat_pulse, 2'b01);
`else
        chk("repeat_e34", pb_repeat_pulse, 2'b00);
`endif
        goto_edge(42);
`ifdef PB_AUTOREPEAT_EN
        chk("repeat_e42", pb_repeat_pulse, 2'b01);
`else
        chk("repeat_e42", pb_repeat_pulse, 2'b00);
`endif
        goto_edge(52);
        pb[0] = 1'b0;
        goto_edge(57);
        chk("release_e57_status", pb_status, 2'b01);
        goto_edge(58);
        chk("release_e58_status",   pb_status,         2'b00);
        chk("release_e58_released", pb_released_pulse, 2'b01);
        chk("release_e58_repeat",   pb_repeat_pulse,   2'b00);
        goto_edge(66);

        // Simultaneous short press: 10 cycles of status high, no hold.
        start_scenario(2'b11);
        goto_edge(6);
        chk("simul_e6_status",  pb_status,        2'b11);
        chk("simul_e6_pressed", pb_pressed_pulse, 2'b11);
        goto_edge(10);
        pb = 2'b00;
        goto_edge(15);
        chk("simul_e15_status", pb_status, 2'b11);
        goto_edge(16);
        chk("simul_e16_status",   pb_status,         2'b00);
        chk("simul_e16_released", pb_released_pulse, 2'b11);
        goto_edge(40);

        // Asynchronous reset mid-press, then re-detect with pb still high.
        start_scenario(2'b01);
        goto_edge(16);
        chk("rstmid_e16_status", pb_status, 2'b01);
        #1 rst = 1'b1;
        #1 chk_all_zero("rstmid_async");
        @(posedge clk);
        #2 rst = 1'b0;
        cur = 0;
        goto_edge(5);
        chk("rstmid_e5_status", pb_status, 2'b00);
        goto_edge(6);
        chk("rstmid_e6_pressed",  pb_pressed_pulse,  2'b01);
        chk("rstmid_e6_released", pb_released_pulse, 2'b00);
        goto_edge(8);
        pb = 2'b00;
        goto_edge(20);

        // Random segments per channel, with occasional asynchronous resets.
        for (int c = 0; c < N; c++) left[c] = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #2;
            for (int c = 0; c < N; c++) begin
                if (left[c] == 0) begin
                    pb[c]   = 1'($urandom_range(0, 1));
                    left[c] = ($urandom_range(0, 9) < 3) ?
                              int'($urandom_range(1, 5)) :
                              int'($urandom_range(6, 70));
                end
                left[c] = left[c] - 1;
            end
            rst = ($urandom_range(0, 399) == 0);
        end
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pb_debouncer_multi.md
Name: pb_debouncer_multi

Overview:
- N-channel successor to the single-button counter debouncer, for front-panel button banks.
- Per channel: 2-FF synchronizer, stable-time counter, debounced status, one-cycle press/release pulses, plus a long-press (hold) pulse.
- Sits between raw board pins and the control FSMs. Optional auto-repeat for menu/step buttons.

Parameters:
N, 4, number of independent button channels (>=1)
DELAY, 15, consecutive synchronized-mismatch cycles required to accept a state change (>=2)
HOLD_CYCLES, 1000, cycles status must stay high after a press before pb_hold_pulse fires (>=1)
REPEAT_CYCLES, 250, auto-repeat period after the hold event (>=1; used only with PB_AUTOREPEAT_EN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
pb  in  N  raw asynchronous button inputs, active-high
pb_status  out  N  debounced level, 1 = pressed
pb_pressed_pulse  out  N  one-cycle pulse on accepted press
pb_released_pulse  out  N  one-cycle pulse on accepted release
pb_hold_pulse  out  N  one-cycle pulse on reaching HOLD_CYCLES while pressed
pb_repeat_pulse  out  N  one-cycle auto-repeat pulse (constant 0 when feature off)

Behaviour:
- One clock (clk); reset is asynchronous and active-high. All flops clear on reset assertion, with no clock needed: sync chain, counters, and all outputs = 0.
- Channels are fully independent; there is no shared state. Everything below applies per channel i.
- Synchronizer: two flops, pb -> s1 -> pb_sync. 2-cycle latency.
- Debounce counter: width $clog2(DELAY+1).
  - Each edge with pb_sync == pb_status: counter <= 0.
  - Each edge with a mismatch: if counter == DELAY-1, toggle pb_status and clear counter; else counter++.
  - Any single agreeing cycle restarts the count (glitch rejection).
- Latency: pb rises just after edge 0 and stays stable -> pb_status = 1 after edge DELAY+2. Release timing is symmetric.
- Pulses are registered:
  - pb_pressed_pulse = 1 for exactly the first cycle pb_status reads 1.
  - pb_released_pulse = 1 for exactly the first cycle pb_status reads 0.
  - Press and release pulses are never both high.
- Hold counter: width $clog2(HOLD_CYCLES+1).
  - Cleared while pb_status == 0.
  - Increments each cycle pb_status == 1, saturating at HOLD_CYCLES.
  - pb_hold_pulse fires for one cycle when the count reaches HOLD_CYCLES, i.e. HOLD_CYCLES cycles after pb_pressed_pulse.
  - At most one hold pulse per press.
- Release before HOLD_CYCLES: no hold pulse; the counter clears on release.
- Reset mid-press: outputs drop to 0 immediately. With pb still high after reset, a fresh press is detected after DELAY+2 edges, with a normal pressed pulse.
- No pulse is ever generated from reset assertion or deassertion alone.

Optional Feature:
- Macro: PB_AUTOREPEAT_EN.
- Defined: per-channel repeat counter, width $clog2(REPEAT_CYCLES+1).
  - Starts at 0 on pb_hold_pulse.
  - While pb_status == 1, pb_repeat_pulse fires every REPEAT_CYCLES cycles after the hold pulse: first at hold+REPEAT_CYCLES, then hold+2*REPEAT_CYCLES, and so on.
  - Stops and clears on release or reset.
- Undefined: no repeat counters are instantiated; pb_repeat_pulse is tied to 0. The port list is identical in both builds.

Test Plan (N=2, DELAY=4, HOLD_CYCLES=20, REPEAT_CYCLES=8; edge 0 = first edge after stimulus):
- Clean press: pb[0] 0->1 and held -> pb_status[0] = 1 after edge 6. pb_pressed_pulse[0] high one cycle after edge 6. Channel 1 outputs stay 0.
- Glitch: pb[1] high for 3 cycles, then low -> pb_status[1], pb_pressed_pulse[1] and the counters never change. Counter returns to 0.
- Hold: continue the clean press -> pb_hold_pulse[0] one cycle after edge 26 and no second hold pulse. With PB_AUTOREPEAT_EN: pb_repeat_pulse[0] after edges 34, 42, 50. Without it: pb_repeat_pulse stays 0.
- Release: pb[0] 1->0 at edge 52 -> pb_status[0] = 0 after edge 58. pb_released_pulse[0] for one cycle. Repeat pulses stop and the hold counter clears.
- Simultaneous/short press: both channels pressed together -> identical, independent timing. A press released after 10 cycles of status high -> no hold pulse.
- Async reset mid-hold: assert reset between clock edges at status=1 -> all outputs 0 before the next edge. Deassert with pb still high -> pressed pulse again after DELAY+2 edges, with no release pulse.
